// File: rtl/hex_sched_pkg.sv
// Shared types and constants for the six-digit hex display scheduler.
package hex_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int unsigned NUM_DIGITS  = 6;
  localparam int unsigned VALUE_W     = 20;
  localparam int unsigned MAX_VALUE   = 999999;
  localparam int unsigned CONV_CYCLES = 20;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Double-dabble correction step: add 3 to every BCD nibble >= 5.
  function automatic logic [4*NUM_DIGITS-1:0] dd_adjust(input logic [4*NUM_DIGITS-1:0] b);
    logic [4*NUM_DIGITS-1:0] r;
    r = b;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_digit_decoder.sv
// Combinational BCD digit to active-low {g,f,e,d,c,b,a} segment decoder.
module seg7_digit_decoder
  import hex_sched_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_display_scheduler.sv
// Converts a 20-bit value to six 7-segment digits: serial double-dabble, then one
// digit per cycle through a shared decoder. Optional macro: LEADING_ZERO_BLANK_EN.
module hex_display_scheduler
  import hex_sched_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] value,
  input  logic        load,
  output logic        ready,
  output logic        done,
  output logic        ovf,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5
);

  state_t                           state_q, state_d;
  logic [VALUE_W-1:0]               bin_q, bin_d;
  logic [4*NUM_DIGITS-1:0]          bcd_q, bcd_d;
  logic [4:0]                       cnt_q, cnt_d;
  logic                             ovf_q, ovf_d;
  logic [NUM_DIGITS-1:0][6:0]       hex_q, hex_d;

  logic [4*NUM_DIGITS-1:0]          bcd_adj;
  logic [6:0]                       dec_seg;
  logic [6:0]                       wr_seg;
  logic                             lead_zero;

  // Digits are consumed from the bottom nibble; bcd_q shifts right once per write.
  seg7_digit_decoder u_dec (
    .digit (bcd_q[3:0]),
    .seg   (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // Remaining bcd_q all zero means this and every higher digit is a leading zero.
  assign lead_zero = (bcd_q == '0) && (cnt_q != '0);
`else
  assign lead_zero = 1'b0;
`endif

  assign bcd_adj = dd_adjust(bcd_q);
  assign wr_seg  = ovf_q ? SEG_DASH : (lead_zero ? SEG_BLANK : dec_seg);

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    hex_d   = hex_q;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          bin_d   = value;
          bcd_d   = '0;
          cnt_d   = '0;
          ovf_d   = (value > VALUE_W'(MAX_VALUE));
          state_d = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        bcd_d = {bcd_adj[4*NUM_DIGITS-2:0], bin_q[VALUE_W-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(CONV_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        hex_d[cnt_q[2:0]] = wr_seg;
        bcd_d = bcd_q >> 4;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(NUM_DIGITS - 1)) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      hex_q   <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      hex_q   <= hex_d;
    end
  end

  assign ready = (state_q == ST_IDLE);
  assign done  = (state_q == ST_DONE);
  assign ovf   = ovf_q;
  assign HEX0  = hex_q[0];
  assign HEX1  = hex_q[1];
  assign HEX2  = hex_q[2];
  assign HEX3  = hex_q[3];
  assign HEX4  = hex_q[4];
  assign HEX5  = hex_q[5];

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Directed table-driven bench for hex_display_scheduler (honours LEADING_ZERO_BLANK_EN).
module tb_hex_display_scheduler;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                         S9 = 7'b0010000, SB = 7'b1111111, SD = 7'b0111111;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = SB;
`else
  localparam logic [6:0] LZ = S0;
`endif

  typedef struct {
    logic [19:0]       value;
    int                inject;   // edge at which a spurious load is pulsed, -1 = none
    logic              exp_ovf;
    logic [5:0][6:0]   exp_hex;  // index 0 = HEX0
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [19:0] value = '0;
  logic        load = 1'b0;
  logic        ready, done, ovf;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  int n_checks = 0;
  int n_fail   = 0;

  hex_display_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .value (value),
    .load  (load),
    .ready (ready),
    .done  (done),
    .ovf   (ovf),
    .HEX0  (HEX0),
    .HEX1  (HEX1),
    .HEX2  (HEX2),
    .HEX3  (HEX3),
    .HEX4  (HEX4),
    .HEX5  (HEX5)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0][6:0] hex_now();
    return {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic run_op(input vec_t t);
    logic [5:0][6:0] prev, cur;
    int done_cnt, done_at;
    prev  = hex_now();
    value = t.value;
    load  = 1'b1;
    @(posedge clk); #1;
    load  = 1'b0;
    chk("ovf_edge0", 32'(ovf), 32'(t.exp_ovf));
    chk("ready_busy", 32'(ready), 32'd0);
    done_cnt = 0;
    done_at  = -1;
    for (int e = 1; e <= 27; e++) begin
      if (e == t.inject) begin
        value = 20'd999999;
        load  = 1'b1;
      end
      @(posedge clk); #1;
      if (e == t.inject) load = 1'b0;
      if (done) begin
        done_cnt++;
        done_at = e;
      end
      cur = hex_now();
      if (e == 20) chk("hex0_hold_convert", 32'(cur[0]), 32'(prev[0]));
      if (e >= 21 && e <= 25) begin
        chk($sformatf("hex%0d_progress", e - 21), 32'(cur[e-21]), 32'(t.exp_hex[e-21]));
        chk($sformatf("hex%0d_hold", e - 20), 32'(cur[e-20]), 32'(prev[e-20]));
      end
      if (e == 26)
        for (int i = 0; i < 6; i++)
          chk($sformatf("hex%0d_final v=%0d", i, t.value), 32'(cur[i]), 32'(t.exp_hex[i]));
    end
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("done_edge", 32'(done_at), 32'd26);
    chk("ready_return", 32'(ready), 32'd1);
    chk("ovf_hold", 32'(ovf), 32'(t.exp_ovf));
  endtask

  vec_t vecs [10];
  vec_t zero_vec;

  initial begin
    int done_cnt;
    vecs[0] = '{20'd123456,  -1, 1'b0, {S1, S2, S3, S4, S5, S6}};
    vecs[1] = '{20'd42,      -1, 1'b0, {LZ, LZ, LZ, LZ, S4, S2}};
    vecs[2] = '{20'd1000000, -1, 1'b1, {SD, SD, SD, SD, SD, SD}};
    vecs[3] = '{20'd5,       10, 1'b0, {LZ, LZ, LZ, LZ, LZ, S5}};
    vecs[4] = '{20'd999999,  -1, 1'b0, {S9, S9, S9, S9, S9, S9}};
    vecs[5] = '{20'd1048575, -1, 1'b1, {SD, SD, SD, SD, SD, SD}};
    vecs[6] = '{20'd100000,  -1, 1'b0, {S1, S0, S0, S0, S0, S0}};
    vecs[7] = '{20'd907,     -1, 1'b0, {LZ, LZ, LZ, S9, S0, S7}};
    vecs[8] = '{20'd864208,  -1, 1'b0, {S8, S6, S4, S2, S0, S8}};
    vecs[9] = '{20'd0,       -1, 1'b0, {LZ, LZ, LZ, LZ, LZ, S0}};
    zero_vec = vecs[9];

    // Asynchronous reset takes effect without a clock edge.
    #2 reset = 1'b1;
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_hex", 32'(hex_now()), 32'({6{SB}}));
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;

    // Back-to-back operations, each starting on the first ready cycle.
    for (int k = 0; k < 10; k++) run_op(vecs[k]);

    // Reset in the middle of the WRITE phase aborts with no done pulse.
    value = 20'd777777;
    load  = 1'b1;
    @(posedge clk); #1;
    load  = 1'b0;
    done_cnt = 0;
    for (int e = 1; e <= 22; e++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    chk("mid_hex0_written", 32'(HEX0), 32'(S7));
    reset = 1'b1;
    #1;
    chk("abort_hex", 32'(hex_now()), 32'({6{SB}}));
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_ovf", 32'(ovf), 32'd0);
    for (int e = 0; e < 3; e++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    reset = 1'b0;
    for (int e = 0; e < 30; e++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    chk("abort_hex_idle", 32'(hex_now()), 32'({6{SB}}));
    run_op(zero_vec);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hex_display_scheduler.md
HEX_DISPLAY_SCHEDULER -- requirements
Module: hex_display_scheduler

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The block SHALL provide these ports:
- clk  input  1  sole clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- value  input  20  unsigned binary number to display.
- load  input  1  request to convert `value`; accepted only when ready=1.
- ready  output  1  block is idle and will accept load.
- done  output  1  one-cycle pulse when all six HEX outputs hold the new value.
- ovf  output  1  the last accepted value exceeded 999999.
- HEX0..HEX5  output  7 each  active-low segments {g,f,e,d,c,b,a}; HEX0 is the least-significant digit.

Function
REQ-003 The block SHALL implement states IDLE, CONVERT, WRITE and DONE.
REQ-004 In IDLE, ready SHALL be 1; in every other state it SHALL be 0.
REQ-005 On the edge where load=1 and ready=1 (edge 0), the block SHALL capture value and enter CONVERT.
REQ-006 In CONVERT, the block SHALL perform a sequential double-dabble, one shift per cycle, at edges 1..20:
- Add 3 to each BCD nibble >=5 before each shift.
- Produce six 4-bit BCD digits.
- Move to WRITE at edge 20.
REQ-007 In WRITE, the block SHALL pass one digit per cycle through a single shared decoder instance:
- Register the result into HEX0 at edge 21, HEX1 at edge 22, ..., HEX5 at edge 26.
- Move to DONE at edge 26.
REQ-008 In DONE, done SHALL be 1 for exactly one cycle; the block SHALL return to IDLE at edge 27.
REQ-009 A HEX output not yet rewritten in the current operation SHALL hold its previous value.
REQ-010 A load while ready=0 SHALL be ignored: no capture, no queueing, no effect on timing.
REQ-011 If the captured value >999999, then:
- ovf SHALL be set at edge 0.
- CONVERT timing SHALL be unchanged.
- WRITE SHALL drive SEG_DASH (7'b0111111) to every digit at the same edges.
REQ-012 If the captured value <=999999, ovf SHALL be cleared at edge 0.
REQ-013 The decoder SHALL map digits 0-9 to 7'b1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, and digits 10-15 to SEG_BLANK (7'b1111111).
REQ-014 Value 0 SHALL display digit 0 on HEX0; its display on HEX1..HEX5 is governed by REQ-017.
REQ-015 The block SHALL accept a load on the first cycle ready returns to 1; back-to-back operations SHALL be 28 cycles apart.

Reset
REQ-016 While reset=1, the block SHALL immediately force:
- state IDLE, ready=1, done=0, ovf=0;
- HEX0..HEX5 = SEG_BLANK;
- internal shift/BCD registers to 0.
Reset mid-operation SHALL abort the operation with no done pulse.

Configuration
REQ-017 Macro LEADING_ZERO_BLANK_EN SHALL control leading-zero display:
- Defined: during WRITE, any digit above the most-significant nonzero digit SHALL be written as SEG_BLANK; HEX0 SHALL always show its digit.
- Undefined: all six digits SHALL be shown, including leading zeros.
- ovf dash display SHALL be unaffected by the macro.

Structure
REQ-018 Package hex_sched_pkg SHALL hold:
- state enum;
- NUM_DIGITS=6, VALUE_W=20, MAX_VALUE=999999, CONV_CYCLES=20;
- SEG_BLANK, SEG_DASH.
REQ-019 Sub-module seg7_digit_decoder SHALL be purely combinational (4-bit digit in, 7-bit active-low segments out), instantiated exactly once.

Verification
REQ-020 Load 123456 -> done at edge 27; HEX5..HEX0 = 1111001, 0100100, 0110000, 0011001, 0010010, 0000010; ovf=0.
REQ-021 Load 42:
- With macro: HEX1=0011001, HEX0=0100100, HEX2..HEX5=1111111.
- Without macro: HEX2..HEX5=1000000.
REQ-022 Load 1000000 -> ovf=1 from edge 0; all HEX = 0111111 after edge 26; done at edge 27.
REQ-023 Load 5, then pulse load with 999999 at edge 10 -> second request ignored; result shows 5 with done at edge 27. Then load 999999 on the ready cycle -> all digits 0010000.
REQ-024 Load 777777, assert reset at edge 23 -> all HEX=1111111, ready=1, no done. Then load 0 -> HEX0=1000000.
